// File: rtl/branch_pkg.sv
// Shared constants and types for the branch predictor: RV32I branch funct3 codes,
// the counter reset value and the target-buffer entry layout.
package branch_pkg;

    localparam int BP_XLEN = 32;

    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd4;
    localparam logic [2:0] BGE  = 3'd5;
    localparam logic [2:0] BLTU = 3'd6;
    localparam logic [2:0] BGEU = 3'd7;

    // Target-buffer entry; the tag holds pc bits above the index, right-aligned.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
    } btb_entry_t;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int ctr_reset_val(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolution and performance-counter signals of the branch predictor.
// master = core pipeline side, slave = predictor.
interface branch_predictor_if #(parameter int XLEN = 32);

    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic [XLEN-1:0] f_pred_target;

    logic            ex_valid;
    logic            ex_branch;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            ex_taken;
    logic            ex_mispredict;
    logic [XLEN-1:0] ex_redirect_pc;

    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    modport master (
        output f_pc, ex_valid, ex_branch, ex_funct3, ex_rs1, ex_rs2, ex_pc,
               ex_target, ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_pred_target, ex_taken, ex_mispredict,
               ex_redirect_pc, perf_branches, perf_mispredicts
    );

    modport slave (
        input  f_pc, ex_valid, ex_branch, ex_funct3, ex_rs1, ex_rs2, ex_pc,
               ex_target, ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_pred_target, ex_taken, ex_mispredict,
               ex_redirect_pc, perf_branches, perf_mispredicts
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational RV32I branch condition evaluator; legal is low for funct3 2 and 3.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) <  $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 <  rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Saturating-counter branch predictor with execute-stage resolution and perf counters.
// Define BP_BTB_EN to add a tagged per-entry branch target buffer.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);

    localparam int               IDX_W    = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_reset_val(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0] ctr_reg [ENTRIES];
    logic [CTR_W-1:0] ctr_next;
    logic [31:0]      perf_br_reg;
    logic [31:0]      perf_mp_reg;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond_taken;
    logic             cond_legal;
    logic             resolved;
    logic             taken_w;
    logic             target_miss;

    assign f_idx  = bus.f_pc[IDX_W+1:2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];

    branch_cond #(.XLEN(XLEN)) u_cond (
        .rs1    (bus.ex_rs1),
        .rs2    (bus.ex_rs2),
        .funct3 (bus.ex_funct3),
        .taken  (cond_taken),
        .legal  (cond_legal)
    );

    assign resolved           = bus.ex_valid & bus.ex_branch & cond_legal;
    assign taken_w            = resolved & cond_taken;
    assign bus.ex_taken       = taken_w;
    assign bus.ex_mispredict  = resolved & ((taken_w != bus.ex_pred_taken) | target_miss);
    assign bus.ex_redirect_pc = taken_w ? bus.ex_target : bus.ex_pc + XLEN'(4);

    always_comb begin
        ctr_next = ctr_reg[ex_idx];
        if (taken_w) begin
            if (ctr_reg[ex_idx] != CTR_MAX) ctr_next = ctr_reg[ex_idx] + CTR_W'(1);
        end else if (ctr_reg[ex_idx] != '0) begin
            ctr_next = ctr_reg[ex_idx] - CTR_W'(1);
        end
    end

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= CTR_INIT;
        end else if (resolved) begin
            ctr_reg[ex_idx] <= ctr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_reg <= '0;
            perf_mp_reg <= '0;
        end else if (resolved) begin
            if (perf_br_reg != '1) perf_br_reg <= perf_br_reg + 32'd1;
            if (bus.ex_mispredict && perf_mp_reg != '1) perf_mp_reg <= perf_mp_reg + 32'd1;
        end
    end

    assign bus.perf_branches    = perf_br_reg;
    assign bus.perf_mispredicts = perf_mp_reg;

`ifdef BP_BTB_EN
    btb_entry_t      btb_reg [ENTRIES];
    logic [XLEN-1:0] f_tag;
    logic [XLEN-1:0] ex_tag;
    logic            btb_hit;
    logic            unused_bits;

    assign f_tag   = bus.f_pc >> (IDX_W + 2);
    assign ex_tag  = bus.ex_pc >> (IDX_W + 2);
    assign btb_hit = btb_reg[f_idx].valid && (btb_reg[f_idx].tag == BP_XLEN'(f_tag));

    assign bus.f_pred_taken  = ctr_reg[f_idx][CTR_W-1] & btb_hit;
    assign bus.f_pred_target = bus.f_pred_taken ? XLEN'(btb_reg[f_idx].target) : '0;
    assign target_miss       = taken_w & bus.ex_pred_taken & (bus.ex_pred_target != bus.ex_target);
    assign unused_bits       = ^bus.f_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb_reg[i] <= '0;
        end else if (taken_w) begin
            btb_reg[ex_idx] <= '{valid: 1'b1, tag: BP_XLEN'(ex_tag), target: BP_XLEN'(bus.ex_target)};
        end
    end
`else
    logic unused_bits;

    // Without target storage decode supplies the target, so only direction is predicted.
    assign bus.f_pred_taken  = ctr_reg[f_idx][CTR_W-1];
    assign bus.f_pred_target = '0;
    assign target_miss       = 1'b0;
    assign unused_bits       = ^{bus.f_pc[XLEN-1:IDX_W+2], bus.f_pc[1:0], bus.ex_pred_target};
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction and resolution unit for the pipelined RV32I core. A fetch-stage lookup port returns a taken/not-taken prediction from a table of saturating counters indexed by PC, with an optional target buffer. An execute-stage resolution port evaluates the branch condition for all six RV32I branch types, flags mispredictions and supplies the redirect PC. The same port trains the table and maintains performance counters.

## Interface
- `XLEN`, 32, data/address width.
- `ENTRIES`, 64, number of prediction entries; power of two ≥ 2.
- `CTR_W`, 2, counter width; ≥ 1.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset; the only clock and reset (single clock domain).
- `f_pc` in XLEN: fetch PC to look up.
- `f_pred_taken` out 1: predicted taken.
- `f_pred_target` out XLEN: predicted target; 0 when not predicted taken.
- `ex_valid` in 1: execute-stage instruction is valid.
- `ex_branch` in 1: instruction is a conditional branch.
- `ex_funct3` in 3: branch type.
- `ex_rs1`, `ex_rs2` in XLEN: operands.
- `ex_pc` in XLEN: branch PC.
- `ex_target` in XLEN: computed target (pc+imm).
- `ex_pred_taken` in 1: prediction carried down the pipe for this branch.
- `ex_pred_target` in XLEN: predicted target carried down the pipe for this branch.
- `ex_taken` out 1: resolved outcome.
- `ex_mispredict` out 1: redirect required.
- `ex_redirect_pc` out XLEN: correct next PC.
- `perf_branches` out 32: resolved-branch count.
- `perf_mispredicts` out 32: mispredict count.

## Operation
- Index = `pc[$clog2(ENTRIES)+1:2]`.
- Counter taken when its MSB = 1.
- Conditions: BEQ (0) `==`; BNE (1) `!=`; BLT (4) signed `<`; BGE (5) signed `>=`; BLTU (6) unsigned `<`; BGEU (7) unsigned `>=`.
- A resolved branch requires `ex_valid & ex_branch` and a legal funct3.
- funct3 2 or 3 is not a resolved branch:
  - `ex_taken` = 0, `ex_mispredict` = 0.
  - No table update, no count.
- When not a resolved branch, `ex_taken`, `ex_mispredict` and `ex_redirect_pc` (driven to `ex_pc+4`) are don't-care for consumers. `ex_mispredict` is forced 0.
- Mispredict conditions:
  - `ex_taken != ex_pred_taken`, or
  - (`BP_BTB_EN` only) `ex_taken & ex_pred_taken & (ex_pred_target != ex_target)`.
- Redirect PC: `ex_redirect_pc` = `ex_taken ? ex_target : ex_pc + 4`. Addition wraps modulo 2^XLEN.
- Table update on a resolved branch, written at the next `clk` edge:
  - Counter increments if taken, decrements otherwise.
  - Counter saturates at 0 and 2^CTR_W−1.
- Perf counters increment on a resolved branch (mispredict counter on mispredict only). Both saturate at 0xFFFF_FFFF, no wrap.

## Timing
- Lookup and resolution outputs are combinational from inputs and current state. Zero-cycle latency.
- A table update becomes visible to lookup one cycle after the resolving cycle.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value.
- Back-to-back updates to one index accumulate: each sees the prior edge's result.
- On `rst_n` low, asynchronously and at any time, including mid-stream:
  - All counters reset to 2^(CTR_W−1)−1 (weakly not-taken; 01 for CTR_W=2).
  - BTB valid bits cleared; perf counters reset to 0.
  - Outputs after reset:
    - `f_pred_taken` = 0, `f_pred_target` = 0.
    - `ex_*` outputs follow inputs combinationally.
- The first edge after deassertion may update state.

## Configuration
- `BP_BTB_EN` defined:
  - Per-entry valid, tag `pc[XLEN-1:$clog2(ENTRIES)+2]` and target.
  - `f_pred_taken` = counter MSB & valid & tag match; `f_pred_target` = stored target.
  - On a resolved taken branch, the entry is written: valid = 1, tag, target.
- `BP_BTB_EN` undefined:
  - No target storage.
  - `f_pred_taken` = counter MSB; `f_pred_target` = 0. Decode supplies the target.
  - Target comparison is omitted from the mispredict condition.

## Structure
- Package `branch_pkg`:
  - funct3 constants `BEQ`, `BNE`, `BLT`, `BGE`, `BLTU`, `BGEU`.
  - Counter reset-value function.
  - `btb_entry_t` struct: valid, tag, target.
- Sub-module `branch_cond`: combinational condition evaluator. Inputs rs1, rs2, funct3. Outputs taken and legal.

## Test plan
- Reset, then lookup `f_pc`=0x100 → `f_pred_taken`=0. Resolve BEQ at 0x100 with rs1=rs2=5, pred 0 → `ex_taken`=1, `ex_mispredict`=1, `ex_redirect_pc`=`ex_target`.
- Train: resolve taken twice at 0x100 (CTR_W=2) → counter 11, lookup taken. Then three not-taken → counter 00; a fourth not-taken stays 00.
- Signed/unsigned: rs1=0xFFFF_FFFF, rs2=1. BLT → taken, BLTU → not taken, BGE → not taken, BGEU → taken.
- Same-cycle lookup and update at index of 0x200 → lookup returns old prediction; the next cycle returns the new one.
- `BP_BTB_EN`: taken branch at 0x300 target 0x400 trained → lookup 0x300 gives target 0x400. Aliasing PC 0x300+4·ENTRIES → tag miss, not taken. funct3=2 → no count, no mispredict.
- Assert `rst_n` mid-stream after 10 branches → perf counters 0, lookups weakly not-taken.
